// File: rtl/traffic_light_monitor.sv
// Passive checker for the one-hot red/yellow/green light bus: tracks the phase,
// latches the first protocol fault and counts completed light cycles.
module traffic_light_monitor #(
    parameter int MIN_RED    = 1,
    parameter int MIN_GREEN  = 1,
    parameter int MIN_YELLOW = 1,
    parameter int MAX_DWELL  = 16,
    parameter int CNT_W      = 5,
    parameter int CYC_W      = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [2:0]       light_i,
    input  logic             clear_fault_i,
    output logic [1:0]       phase_o,
    output logic             phase_valid_o,
    output logic             fault_o,
    output logic [2:0]       fault_code_o,
    output logic [CNT_W-1:0] dwell_o,
    output logic [CYC_W-1:0] cycles_o
);

    // state  | meaning
    // INIT   | no phase tracked yet (after reset, clear, or dark bus)
    // RED    | tracking red
    // YELLOW | tracking yellow
    // GREEN  | tracking green
    // FAULT  | fault latched; light ignored until clear_fault_i
    typedef enum logic [2:0] {
        S_INIT, S_RED, S_YELLOW, S_GREEN, S_FAULT
    } state_t;

    localparam logic [2:0] FC_NONE  = 3'd0;
    localparam logic [2:0] FC_CODE  = 3'd1;
    localparam logic [2:0] FC_ORDER = 3'd2;
    localparam logic [2:0] FC_SHORT = 3'd3;
    localparam logic [2:0] FC_STUCK = 3'd4;

    localparam logic [CNT_W-1:0] MAX_D   = CNT_W'(MAX_DWELL);
    localparam logic [CNT_W-1:0] MIN_R_D = CNT_W'(MIN_RED);
    localparam logic [CNT_W-1:0] MIN_G_D = CNT_W'(MIN_GREEN);
    localparam logic [CNT_W-1:0] MIN_Y_D = CNT_W'(MIN_YELLOW);

    state_t             state_q, state_d;
    logic [2:0]         code_q, code_d;
    logic [CNT_W-1:0]   dwell_q, dwell_d;
    logic [CYC_W-1:0]   cycles_q, cycles_d;

    state_t             light_st;
    logic               light_ok;
    state_t             legal_next;
    logic [CNT_W-1:0]   min_cur;

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q  <= S_INIT;
            code_q   <= FC_NONE;
            dwell_q  <= '0;
            cycles_q <= '0;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            dwell_q  <= dwell_d;
            cycles_q <= cycles_d;
        end
    end

    // S_INIT doubles as the "not a one-hot code" marker for the decoded bus
    always_comb begin
        light_st = S_INIT;
        case (light_i)
            3'b100:  light_st = S_RED;
            3'b010:  light_st = S_YELLOW;
            3'b001:  light_st = S_GREEN;
            default: light_st = S_INIT;
        endcase
        light_ok = (light_st != S_INIT);

        legal_next = S_INIT;
        min_cur    = '0;
        case (state_q)
            S_RED:    begin legal_next = S_GREEN;  min_cur = MIN_R_D; end
            S_GREEN:  begin legal_next = S_YELLOW; min_cur = MIN_G_D; end
            S_YELLOW: begin legal_next = S_RED;    min_cur = MIN_Y_D; end
            default:  begin legal_next = S_INIT;   min_cur = '0;      end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        dwell_d  = dwell_q;
        cycles_d = cycles_q;
        case (state_q)
            S_INIT: begin
                if (light_i == 3'b000) begin
                    state_d = S_INIT;
                end else if (light_ok) begin
                    state_d = light_st;
                    dwell_d = CNT_W'(1);
                end else begin
                    state_d = S_FAULT;
                    code_d  = FC_CODE;
                end
            end
            S_RED, S_YELLOW, S_GREEN: begin
                if (!light_ok) begin
                    state_d = S_FAULT;
                    code_d  = FC_CODE;
                end else if (light_st == state_q) begin
                    if (dwell_q == MAX_D) begin
                        state_d = S_FAULT;
                        code_d  = FC_STUCK;
                    end else begin
                        dwell_d = dwell_q + 1'b1;
                    end
                end else if (light_st == legal_next) begin
                    if (dwell_q < min_cur) begin
                        state_d = S_FAULT;
                        code_d  = FC_SHORT;
                    end else begin
                        state_d = light_st;
                        dwell_d = CNT_W'(1);
                        if (state_q == S_YELLOW) cycles_d = cycles_q + 1'b1;
                    end
                end else begin
                    state_d = S_FAULT;
                    code_d  = FC_ORDER;
                end
            end
            S_FAULT: begin
                if (clear_fault_i) begin
                    state_d = S_INIT;
                    code_d  = FC_NONE;
                    dwell_d = '0;
                end
            end
            default: begin
                state_d = S_INIT;
                code_d  = FC_NONE;
                dwell_d = '0;
            end
        endcase
    end

    always_comb begin
        phase_o       = 2'b11;
        phase_valid_o = 1'b0;
        case (state_q)
            S_RED:    begin phase_o = 2'b00; phase_valid_o = 1'b1; end
            S_YELLOW: begin phase_o = 2'b01; phase_valid_o = 1'b1; end
            S_GREEN:  begin phase_o = 2'b10; phase_valid_o = 1'b1; end
            default:  begin phase_o = 2'b11; phase_valid_o = 1'b0; end
        endcase
        fault_o      = (state_q == S_FAULT);
        fault_code_o = code_q;
        dwell_o      = dwell_q;
        cycles_o     = cycles_q;
    end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor: a vector table for the main protocol
// plus hand sequences for minimum-dwell and maximum-dwell corner cases.
module tb_traffic_light_monitor;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [2:0] light;
    logic       clear_fault;

    logic [1:0] phase_a,  phase_b;
    logic       valid_a,  valid_b;
    logic       fault_a,  fault_b;
    logic [2:0] code_a,   code_b;
    logic [4:0] dwell_a,  dwell_b;
    logic [7:0] cycles_a, cycles_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    traffic_light_monitor dut (
        .clk_i         (clk),
        .reset_i       (reset_n),
        .light_i       (light),
        .clear_fault_i (clear_fault),
        .phase_o       (phase_a),
        .phase_valid_o (valid_a),
        .fault_o       (fault_a),
        .fault_code_o  (code_a),
        .dwell_o       (dwell_a),
        .cycles_o      (cycles_a)
    );

    traffic_light_monitor #(.MIN_GREEN(3)) dut_g3 (
        .clk_i         (clk),
        .reset_i       (reset_n),
        .light_i       (light),
        .clear_fault_i (clear_fault),
        .phase_o       (phase_b),
        .phase_valid_o (valid_b),
        .fault_o       (fault_b),
        .fault_code_o  (code_b),
        .dwell_o       (dwell_b),
        .cycles_o      (cycles_b)
    );

    typedef struct {
        logic [2:0] light;
        logic       clr;
        logic       rst_n;
        logic [19:0] exp;
    } vec_t;

    vec_t vecs[$];

    // packed as {phase, valid, fault, code, dwell, cycles}
    function automatic logic [19:0] pk(logic [1:0] p, logic v, logic f,
                                       logic [2:0] c, logic [4:0] d, logic [7:0] cy);
        return {p, v, f, c, d, cy};
    endfunction

    function automatic void add(logic [2:0] l, logic c, logic r, logic [19:0] e);
        vec_t t;
        t.light = l; t.clr = c; t.rst_n = r; t.exp = e;
        vecs.push_back(t);
    endfunction

    task automatic step(logic [2:0] l, logic c, logic r);
        @(negedge clk);
        light = l; clear_fault = c; reset_n = r;
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, logic [19:0] act, logic [19:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got ph=%b v=%b f=%b code=%0d dwell=%0d cyc=%0d, want ph=%b v=%b f=%b code=%0d dwell=%0d cyc=%0d",
                     name, act[19:18], act[17], act[16], act[15:13], act[12:8], act[7:0],
                     exp[19:18], exp[17], exp[16], exp[15:13], exp[12:8], exp[7:0]);
        end
    endtask

    function automatic logic [19:0] out_a();
        return {phase_a, valid_a, fault_a, code_a, dwell_a, cycles_a};
    endfunction

    function automatic logic [19:0] out_b();
        return {phase_b, valid_b, fault_b, code_b, dwell_b, cycles_b};
    endfunction

    logic [19:0] RST;
    logic [2:0]  legal[3];

    initial begin
        reset_n = 1'b0; light = 3'b000; clear_fault = 1'b0;
        RST = pk(2'b11, 0, 0, 0, 0, 0);
        legal[0] = 3'b001; legal[1] = 3'b010; legal[2] = 3'b100;

        // normal cycling, three full cycles
        add(3'b000, 0, 0, RST);
        add(3'b100, 0, 1, pk(0, 1, 0, 0, 1, 0));
        for (int k = 0; k < 3; k++) begin
            add(3'b001, 0, 1, pk(2, 1, 0, 0, 1, 8'(k)));
            add(3'b010, 0, 1, pk(1, 1, 0, 0, 1, 8'(k)));
            add(3'b100, 0, 1, pk(0, 1, 0, 0, 1, 8'(k + 1)));
        end
        // out of order from red, then light ignored while faulted
        add(3'b010, 0, 1, pk(3, 0, 1, 2, 1, 3));
        for (int k = 0; k < 10; k++) add(legal[k % 3], 0, 1, pk(3, 0, 1, 2, 1, 3));
        // reset wins over clear_fault and clears cycles
        add(3'b001, 1, 0, RST);
        // bad encoding in GREEN
        add(3'b100, 0, 1, pk(0, 1, 0, 0, 1, 0));
        add(3'b001, 0, 1, pk(2, 1, 0, 0, 1, 0));
        add(3'b011, 0, 1, pk(3, 0, 1, 1, 1, 0));
        add(3'b000, 0, 0, RST);
        // dark bus keeps INIT, then bad code from INIT
        for (int k = 0; k < 5; k++) add(3'b000, 0, 1, RST);
        add(3'b110, 0, 1, pk(3, 0, 1, 1, 0, 0));
        add(3'b100, 1, 1, RST);
        add(3'b100, 0, 1, pk(0, 1, 0, 0, 1, 0));
        add(3'b000, 0, 1, pk(3, 0, 1, 1, 1, 0));
        add(3'b000, 0, 0, RST);
        // clear_fault keeps cycles; clear in tracking state is ignored
        add(3'b100, 0, 1, pk(0, 1, 0, 0, 1, 0));
        add(3'b001, 0, 1, pk(2, 1, 0, 0, 1, 0));
        add(3'b010, 0, 1, pk(1, 1, 0, 0, 1, 0));
        add(3'b100, 0, 1, pk(0, 1, 0, 0, 1, 1));
        add(3'b001, 0, 1, pk(2, 1, 0, 0, 1, 1));
        add(3'b010, 0, 1, pk(1, 1, 0, 0, 1, 1));
        add(3'b100, 0, 1, pk(0, 1, 0, 0, 1, 2));
        add(3'b010, 0, 1, pk(3, 0, 1, 2, 1, 2));
        add(3'b001, 1, 1, pk(3, 0, 0, 0, 0, 2));
        add(3'b100, 0, 1, pk(0, 1, 0, 0, 1, 2));
        add(3'b100, 1, 1, pk(0, 1, 0, 0, 2, 2));
        add(3'b001, 1, 1, pk(2, 1, 0, 0, 1, 2));
        add(3'b001, 0, 0, RST);
        // 111 from INIT
        add(3'b111, 0, 1, pk(3, 0, 1, 1, 0, 0));

        foreach (vecs[i]) begin
            step(vecs[i].light, vecs[i].clr, vecs[i].rst_n);
            check($sformatf("vec%0d", i), out_a(), vecs[i].exp);
        end

        // maximum dwell: 16 red samples legal, 17th is stuck
        step(3'b000, 0, 0);
        for (int i = 1; i <= 16; i++) begin
            step(3'b100, 0, 1);
            check($sformatf("hold_red_%0d", i), out_a(), pk(0, 1, 0, 0, 5'(i), 0));
        end
        step(3'b100, 0, 1);
        check("stuck_red", out_a(), pk(3, 0, 1, 4, 16, 0));
        step(3'b100, 0, 1);
        check("stuck_hold", out_a(), pk(3, 0, 1, 4, 16, 0));

        // at dwell==MAX: legal change is fine, wrong order beats stuck, bad code beats all
        step(3'b000, 0, 0);
        for (int i = 0; i < 16; i++) step(3'b100, 0, 1);
        step(3'b001, 0, 1);
        check("leave_at_max", out_a(), pk(2, 1, 0, 0, 1, 0));
        step(3'b000, 0, 0);
        for (int i = 0; i < 16; i++) step(3'b100, 0, 1);
        step(3'b010, 0, 1);
        check("order_at_max", out_a(), pk(3, 0, 1, 2, 16, 0));
        step(3'b000, 0, 0);
        for (int i = 0; i < 16; i++) step(3'b100, 0, 1);
        step(3'b000, 0, 1);
        check("dark_at_max", out_a(), pk(3, 0, 1, 1, 16, 0));

        // MIN_GREEN=3 instance: two green cycles is short, three is enough
        step(3'b000, 0, 0);
        step(3'b100, 0, 1);
        check("g3_red", out_b(), pk(0, 1, 0, 0, 1, 0));
        step(3'b001, 0, 1);
        step(3'b001, 0, 1);
        check("g3_green2", out_b(), pk(2, 1, 0, 0, 2, 0));
        step(3'b010, 0, 1);
        check("g3_short", out_b(), pk(3, 0, 1, 3, 2, 0));
        step(3'b000, 0, 0);
        step(3'b100, 0, 1);
        for (int i = 0; i < 3; i++) step(3'b001, 0, 1);
        check("g3_green3", out_b(), pk(2, 1, 0, 0, 3, 0));
        step(3'b010, 0, 1);
        check("g3_yellow_ok", out_b(), pk(1, 1, 0, 0, 1, 0));
        step(3'b100, 0, 1);
        check("g3_cycle", out_b(), pk(0, 1, 0, 0, 1, 1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
